// File: rtl/capture_ctrl.sv
// capture_ctrl: sequences sample writes into the five RAMqueues.
//
// Generates the shared RAMqueue write address/enable. The block arms once
// enough pre-trigger history is stored, counts post-trigger samples against
// trig_pos, pulses set_capture_done, and then freezes waddr. The address stays
// frozen until the host clears the done bit, so a dump starting at waddr begins
// with the oldest sample.
//
// Optional build macro: AUTO_TRIG_EN. When it is defined, a forced trigger
// fires after AUTO_TRIG_SMPLS armed writes that saw no real trigger.
//
// Ports:
//   clk              system clock
//   rst              asynchronous active-high reset
//   wrt_smpl         one-cycle strobe per decimated sample
//   run_en           capture requested (TrigCfg[4])
//   capture_done     done bit held in cmd_cfg (TrigCfg[5])
//   triggered        trigger level, qualified by armed
//   trig_pos         post-trigger sample count
//   we               RAMqueue write enable (all channels)
//   waddr            RAMqueue write address / dump start address
//   armed            pre-trigger history complete
//   set_capture_done one-cycle pulse to cmd_cfg
//   capturing        high in CAPTURE state
module capture_ctrl #(
    parameter int unsigned ENTRIES         = 384,
    parameter int unsigned LOG2            = 9,
    parameter logic [15:0] AUTO_TRIG_SMPLS = 16'hFFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wrt_smpl,
    input  logic            run_en,
    input  logic            capture_done,
    input  logic            triggered,
    input  logic [LOG2-1:0] trig_pos,
    output logic            we,
    output logic [LOG2-1:0] waddr,
    output logic            armed,
    output logic            set_capture_done,
    output logic            capturing
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    // Counters are one bit wider than the address so ENTRIES == 2**LOG2 works.
    localparam logic [LOG2:0]   EntW     = (LOG2+1)'(ENTRIES);
    localparam logic [LOG2:0]   EntM1W   = (LOG2+1)'(ENTRIES - 1);
    localparam logic [LOG2:0]   CntOne   = (LOG2+1)'(1);
    localparam logic [LOG2-1:0] LastAddr = (LOG2)'(ENTRIES - 1);
    localparam logic [LOG2-1:0] AddrOne  = (LOG2)'(1);

    logic [1:0]      state_q, state_d;
    logic [LOG2-1:0] waddr_q, waddr_d;
    logic [LOG2:0]   smpl_cnt_q, smpl_cnt_d;
    logic [LOG2:0]   post_cnt_q, post_cnt_d;
    logic            trig_seen_q, trig_seen_d;
    logic            armed_q, armed_d;
    logic            done_q, done_d;
    logic            capturing_q, capturing_d;

    logic [LOG2:0]   trig_pos_w;
    logic [LOG2:0]   tp;
    logic [LOG2:0]   arm_thresh;
    logic            we_int;
    logic            trig_hit;
    logic            done_hit;
    logic            auto_fire;

    // Effective post-trigger count: at least one sample, and at least one
    // sample of pre-trigger history.
    always_comb begin
        trig_pos_w = {1'b0, trig_pos};
        if (trig_pos_w == '0) begin
            tp = CntOne;
        end else if (trig_pos_w >= EntW) begin
            tp = EntM1W;
        end else begin
            tp = trig_pos_w;
        end
        arm_thresh = EntW - tp;
    end

    assign we_int = (state_q == CAPTURE) && wrt_smpl;

    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        smpl_cnt_d  = smpl_cnt_q;
        post_cnt_d  = post_cnt_q;
        trig_seen_d = trig_seen_q;
        armed_d     = armed_q;
        done_d      = 1'b0;
        trig_hit    = 1'b0;
        done_hit    = 1'b0;

        case (state_q)
            IDLE: begin
                // waddr is kept so the ring continues where it stopped.
                if (run_en && !capture_done) begin
                    state_d     = CAPTURE;
                    smpl_cnt_d  = '0;
                    post_cnt_d  = '0;
                    trig_seen_d = 1'b0;
                    armed_d     = 1'b0;
                end
            end
            CAPTURE: begin
                if (we_int) begin
                    waddr_d = (waddr_q == LastAddr) ? '0 : waddr_q + AddrOne;
                    if (smpl_cnt_q != EntW) begin
                        smpl_cnt_d = smpl_cnt_q + CntOne;
                        if (smpl_cnt_q + CntOne == arm_thresh) begin
                            armed_d = 1'b1;
                        end
                    end
                end
                // The triggering write itself is post-trigger sample 1.
                trig_hit = we_int && armed_q && !trig_seen_q && (triggered || auto_fire);
                if (trig_hit) begin
                    trig_seen_d = 1'b1;
                end
                if (we_int && (trig_seen_q || trig_hit)) begin
                    post_cnt_d = post_cnt_q + CntOne;
                    done_hit   = (post_cnt_q + CntOne == tp);
                end
                // An abort wins over a simultaneous completion: no done pulse.
                if (!run_en) begin
                    state_d = IDLE;
                end else if (done_hit) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                if (!capture_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != CAPTURE) begin
            armed_d = 1'b0;
        end
        capturing_d = (state_d == CAPTURE);
    end

`ifdef AUTO_TRIG_EN
    logic [15:0] auto_cnt_q, auto_cnt_d;

    assign auto_fire = (auto_cnt_q == AUTO_TRIG_SMPLS);

    always_comb begin
        auto_cnt_d = auto_cnt_q;
        if (armed_d && !armed_q) begin
            auto_cnt_d = '0;
        end else if (we_int && armed_q && !trig_seen_q && !auto_fire) begin
            auto_cnt_d = auto_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end
`else
    logic unused_auto_smpls;
    assign unused_auto_smpls = ^AUTO_TRIG_SMPLS;
    assign auto_fire         = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            smpl_cnt_q  <= '0;
            post_cnt_q  <= '0;
            trig_seen_q <= 1'b0;
            armed_q     <= 1'b0;
            done_q      <= 1'b0;
            capturing_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            smpl_cnt_q  <= smpl_cnt_d;
            post_cnt_q  <= post_cnt_d;
            trig_seen_q <= trig_seen_d;
            armed_q     <= armed_d;
            done_q      <= done_d;
            capturing_q <= capturing_d;
        end
    end

    assign we               = we_int;
    assign waddr            = waddr_q;
    assign armed            = armed_q;
    assign set_capture_done = done_q;
    assign capturing        = capturing_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed self-checking bench for capture_ctrl.
// Expected dump-start addresses are queued before the completing write and
// popped when set_capture_done is seen; the bench also plays cmd_cfg by
// setting capture_done on the pulse.
module tb_capture_ctrl;

    localparam int unsigned ENTRIES = 384;
    localparam int unsigned LOG2    = 9;

    logic            clk = 1'b0;
    logic            rst;
    logic            wrt_smpl;
    logic            run_en;
    logic            capture_done;
    logic            triggered;
    logic [LOG2-1:0] trig_pos;
    logic            we;
    logic [LOG2-1:0] waddr;
    logic            armed;
    logic            set_capture_done;
    logic            capturing;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    logic last_we;
    logic any_we;

    capture_ctrl #(
        .ENTRIES(ENTRIES),
        .LOG2   (LOG2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .wrt_smpl        (wrt_smpl),
        .run_en          (run_en),
        .capture_done    (capture_done),
        .triggered       (triggered),
        .trig_pos        (trig_pos),
        .we              (we),
        .waddr           (waddr),
        .armed           (armed),
        .set_capture_done(set_capture_done),
        .capturing       (capturing)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One sample strobe; returns on the negedge after the write edge.
    task automatic smpl(input logic trg);
        @(negedge clk);
        wrt_smpl  = 1'b1;
        triggered = trg;
        #1 last_we = we;
        @(negedge clk);
        wrt_smpl  = 1'b0;
        triggered = 1'b0;
        if (set_capture_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("done_unexpected", int'(set_capture_done), 0);
            end else begin
                chk("done_waddr", int'(waddr), exp_q.pop_front());
            end
            capture_done = 1'b1;
        end
    endtask

    task automatic smpls(input int n);
        for (int i = 0; i < n; i++) smpl(1'b0);
    endtask

    task automatic start(input int tpv);
        @(negedge clk);
        run_en       = 1'b0;
        capture_done = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        trig_pos = tpv[LOG2-1:0];
        run_en   = 1'b1;
        @(negedge clk);
        chk("start_capturing", int'(capturing), 1);
        chk("start_waddr", int'(waddr), 0);
    endtask

    initial begin
        rst          = 1'b1;
        wrt_smpl     = 1'b0;
        run_en       = 1'b0;
        capture_done = 1'b0;
        triggered    = 1'b0;
        trig_pos     = '0;
        #23;
        chk("rst_we", int'(we), 0);
        chk("rst_waddr", int'(waddr), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_done", int'(set_capture_done), 0);
        chk("rst_capturing", int'(capturing), 0);

        // trig_pos=1: arm after write 383, trigger at write 400.
        start(1);
        smpls(382);
        chk("a_armed_382", int'(armed), 0);
        smpl(1'b0);
        chk("a_armed_383", int'(armed), 1);
        smpls(16);
        chk("a_no_done_399", int'(set_capture_done), 0);
        exp_q.push_back(16);
        smpl(1'b1);
        chk("a_done_pulse", int'(set_capture_done), 1);
        chk("a_capturing_done", int'(capturing), 0);
        chk("a_armed_done", int'(armed), 0);
        @(negedge clk);
        chk("a_done_one_cycle", int'(set_capture_done), 0);
        chk("a_sb_empty", exp_q.size(), 0);

        // Frozen in DONE while the host holds capture_done.
        any_we = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            smpl(1'b1);
            any_we = any_we | last_we;
        end
        chk("hold_we", int'(any_we), 0);
        chk("hold_waddr", int'(waddr), 16);
        chk("hold_capturing", int'(capturing), 0);
        capture_done = 1'b0;
        @(negedge clk);
        chk("resume_idle", int'(capturing), 0);
        @(negedge clk);
        chk("resume_capturing", int'(capturing), 1);
        chk("resume_waddr", int'(waddr), 16);
        smpl(1'b0);
        chk("resume_write", int'(waddr), 17);
        chk("resume_we", int'(last_we), 1);

        // Asynchronous reset in the middle of a capture.
        @(negedge clk);
        wrt_smpl = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_we", int'(we), 0);
        chk("arst_waddr", int'(waddr), 0);
        chk("arst_armed", int'(armed), 0);
        chk("arst_capturing", int'(capturing), 0);
        chk("arst_done", int'(set_capture_done), 0);
        @(negedge clk);
        wrt_smpl = 1'b0;
        chk("arst_done_later", int'(set_capture_done), 0);

        // trig_pos=100: early trigger ignored, arm at 284, trigger at 300.
        start(100);
        smpls(9);
        smpl(1'b1);
        smpls(273);
        chk("b_armed_283", int'(armed), 0);
        smpl(1'b0);
        chk("b_armed_284", int'(armed), 1);
        smpls(15);
        smpl(1'b1);
        smpls(98);
        chk("b_no_done_398", int'(set_capture_done), 0);
        exp_q.push_back(15);
        smpl(1'b0);
        chk("b_done_pulse", int'(set_capture_done), 1);
        chk("b_sb_empty", exp_q.size(), 0);

        // Abort: run_en falls together with write 50.
        start(5);
        smpls(49);
        @(negedge clk);
        wrt_smpl = 1'b1;
        run_en   = 1'b0;
        @(negedge clk);
        wrt_smpl = 1'b0;
        chk("abort_capturing", int'(capturing), 0);
        chk("abort_waddr", int'(waddr), 50);
        chk("abort_done", int'(set_capture_done), 0);
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("abort_done_later", int'(set_capture_done), 0);
        chk("abort_waddr_held", int'(waddr), 50);
        chk("abort_capture_done", int'(capture_done), 0);

        // trig_pos=0 behaves as 1; address wraps 383 -> 0.
        start(0);
        smpls(383);
        chk("wrap_waddr_383", int'(waddr), 383);
        chk("wrap_armed", int'(armed), 1);
        smpl(1'b0);
        chk("wrap_waddr_0", int'(waddr), 0);
        exp_q.push_back(1);
        smpl(1'b1);
        chk("wrap_done", int'(set_capture_done), 1);

        // trig_pos >= ENTRIES behaves as ENTRIES-1: arm after one write.
        start(500);
        smpl(1'b0);
        chk("clamp_armed_1", int'(armed), 1);
        smpl(1'b1);
        smpls(381);
        chk("clamp_no_done", int'(set_capture_done), 0);
        exp_q.push_back(0);
        smpl(1'b0);
        chk("clamp_done", int'(set_capture_done), 1);
        chk("clamp_sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
